direction_decoder: RTL and testbench
====================================

Name: direction_decoder

Overview:
- Consumes the PS/2 scan-code byte stream and one player's four mapped key codes (left/right/up/down bytes from the keyset control mapping).
- Tracks make/break state of the four keys.
- Latches the most recent direction request and commits it to the bike heading on each game tick, rejecting 180-degree reversals.
- One instance per player, downstream of that player's key-code mapping.

Parameters:
- RESET_DIR, 2'd1, heading loaded at reset (encoding: 0=up, 1=right, 2=down, 3=left).

Ports:
- clock  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- scan_code  input  8  received PS/2 byte, valid only when scan_valid=1.
- scan_valid  input  1  one-cycle strobe per received byte.
- left_code  input  8  make code mapped to left.
- right_code  input  8  make code mapped to right.
- up_code  input  8  make code mapped to up.
- down_code  input  8  make code mapped to down.
- tick  input  1  one-cycle game-step strobe; heading commits here.
- dir  output  2  current committed heading.
- dir_changed  output  1  one-cycle pulse, cycle after a commit that altered dir.
- key_held  output  4  {left,down,right,up} currently-pressed bitmap.
- req_pending  output  1  a direction request is waiting for the next tick.

Behaviour:
- Reset values (asynchronous, applied immediately): dir=RESET_DIR, dir_changed=0, key_held=4'b0, req_pending=0, parser state=IDLE, pending request register=0.
- Parser FSM advances only on cycles with scan_valid=1. States:
  - IDLE: 8'hE0 -> EXT; 8'hF0 -> BRK; mapped code -> make event, stay IDLE; any other byte (including 8'hAA, 8'hFA) -> ignored, stay IDLE.
  - EXT: 8'hF0 -> EXT_BRK; any other byte -> make event if mapped, then -> IDLE.
  - BRK: any byte -> break event if mapped, then -> IDLE.
  - EXT_BRK: any byte -> break event if mapped, then -> IDLE.
  - The E0 prefix does not affect matching: "E0 xx" and "xx" match identically.
- Matching:
  - scan_code is compared against the four code inputs, sampled in the same cycle.
  - If several codes are equal, priority is up > right > down > left; only one event is produced.
- Make event for direction d:
  - key_held[d] <= 1.
  - Pending request <= d; req_pending <= 1.
  - Last make before a tick wins.
  - A repeated make (typematic) re-asserts the same request.
- Break event for direction d: key_held[d] <= 0. The pending request is unaffected.
- Tick with req_pending=1:
  - If request == (dir ^ 2'b10), i.e. a reversal, the request is discarded. dir unchanged, no pulse.
  - Else if request == dir: no change, no pulse.
  - Else: dir <= request, and dir_changed=1 for exactly the following cycle.
  - req_pending <= 0 in all three cases.
- Tick with req_pending=0: no effect.
- Tick and make event in the same cycle:
  - The tick commits the request held before this cycle.
  - The new make becomes the pending request, so req_pending=1 after the cycle.
- Commit latency: tick at cycle N -> dir updated and dir_changed high at cycle N+1.
- Mapping inputs changing mid-stream: take effect on the next scan_valid byte; parser state is kept.
- Reset asserted mid-sequence (e.g. after F0) returns the parser to IDLE. The next byte is treated as a fresh code.

Test Plan:
- Reset with codes up=1D, right=23, down=1B, left=1C -> dir=1, key_held=0, req_pending=0, dir_changed=0.
- Byte 1D, then tick -> req_pending=1 after the byte; the cycle after the tick gives dir=0, dir_changed pulse of 1 cycle, req_pending=0, key_held=4'b0001.
- From dir=0 send 1B, then tick -> reversal rejected: dir stays 0, no pulse, req_pending=0, key_held=4'b0100.
- Sequence E0 F0 1D -> key_held[0] cleared, dir unchanged, parser in IDLE. Then F0 55 (unmapped) -> no change.
- Bytes 23 then 1C within one tick period from dir=0, then tick -> dir=3 (last make wins), dir_changed pulses.
- 1B arrives on the same cycle as a tick while the pending request is 23 -> dir=1 the next cycle, req_pending=1 with request 2. A second tick gives dir=2 (allowed, because dir is now 1).

Source files
------------

// File: rtl/direction_decoder.sv
// PS/2 scan-code direction decoder for one player: tracks the four mapped keys,
// latches the latest direction request and commits it on each game tick (no reversals).
module direction_decoder #(
   parameter logic [1:0] RESET_DIR = 2'd1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic [7:0] left_code,
   input  logic [7:0] right_code,
   input  logic [7:0] up_code,
   input  logic [7:0] down_code,
   input  logic       tick,
   output logic [1:0] dir,
   output logic       dir_changed,
   output logic [3:0] key_held,
   output logic       req_pending
);

   localparam int unsigned DIR_W  = 2;
   localparam int unsigned KEY_N  = 4;
   localparam logic [7:0]  EXT_PFX = 8'hE0;
   localparam logic [7:0]  BRK_PFX = 8'hF0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } pstate_t;

   pstate_t            state, state_nxt;
   logic               hit;
   logic [DIR_W-1:0]   hit_dir;
   logic               make_ev_c;
   logic               brk_ev_c;
   logic [DIR_W-1:0]   req;

   // Code match with fixed priority up > right > down > left
   always_comb begin
      hit     = 1'b1;
      hit_dir = DIR_W'(0);
      if (scan_code == up_code)         hit_dir = DIR_W'(0);
      else if (scan_code == right_code) hit_dir = DIR_W'(1);
      else if (scan_code == down_code)  hit_dir = DIR_W'(2);
      else if (scan_code == left_code)  hit_dir = DIR_W'(3);
      else                              hit = 1'b0;
   end

   // Parser state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Parser next state; prefixes take precedence over mapped codes
   always_comb begin
      state_nxt = state;
      if (scan_valid) begin
         case (state)
            IDLE: begin
               if (scan_code == EXT_PFX)      state_nxt = EXT;
               else if (scan_code == BRK_PFX) state_nxt = BRK;
            end
            EXT: begin
               if (scan_code == BRK_PFX) state_nxt = EXT_BRK;
               else                      state_nxt = IDLE;
            end
            BRK:     state_nxt = IDLE;
            EXT_BRK: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Parser event decode
   always_comb begin
      make_ev_c = 1'b0;
      brk_ev_c  = 1'b0;
      if (scan_valid && hit) begin
         case (state)
            IDLE:    make_ev_c = (scan_code != EXT_PFX) && (scan_code != BRK_PFX);
            EXT:     make_ev_c = (scan_code != BRK_PFX);
            BRK:     brk_ev_c  = 1'b1;
            EXT_BRK: brk_ev_c  = 1'b1;
            default: ;
         endcase
      end
   end

   // Key bitmap, pending request and heading commit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dir         <= RESET_DIR;
         dir_changed <= 1'b0;
         key_held    <= KEY_N'(0);
         req_pending <= 1'b0;
         req         <= DIR_W'(0);
      end else begin
         dir_changed <= 1'b0;
         if (tick && req_pending) begin
            req_pending <= 1'b0;
            if ((req != (dir ^ 2'b10)) && (req != dir)) begin
               dir         <= req;
               dir_changed <= 1'b1;
            end
         end
         if (make_ev_c) begin
            key_held[hit_dir] <= 1'b1;
            req               <= hit_dir;
            req_pending       <= 1'b1;
         end else if (brk_ev_c) begin
            key_held[hit_dir] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_direction_decoder.sv
// Bench for direction_decoder: directed literal checks plus randomized byte/tick
// traffic compared every cycle against a behavioural model.
module tb_direction_decoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic [7:0] left_code = 8'h1C;
   logic [7:0] right_code = 8'h23;
   logic [7:0] up_code = 8'h1D;
   logic [7:0] down_code = 8'h1B;
   logic       tick = 1'b0;
   logic [1:0] dir;
   logic       dir_changed;
   logic [3:0] key_held;
   logic       req_pending;

   int checks = 0;
   int failures = 0;

   direction_decoder #(.RESET_DIR(2'd1)) dut (
      .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
      .left_code(left_code), .right_code(right_code), .up_code(up_code),
      .down_code(down_code), .tick(tick), .dir(dir), .dir_changed(dir_changed),
      .key_held(key_held), .req_pending(req_pending)
   );

   always #5 clock = ~clock;

   // Behavioural model: heading as integer, keys as a flag array, parser as prefix flags
   int m_dir, m_req;
   bit m_changed, m_pend, m_ext, m_brk;
   bit m_held [4];

   function automatic int match(input logic [7:0] c);
      if (c == up_code)    return 0;
      if (c == right_code) return 1;
      if (c == down_code)  return 2;
      if (c == left_code)  return 3;
      return -1;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_dir = 1; m_req = 0; m_changed = 0; m_pend = 0; m_ext = 0; m_brk = 0;
         foreach (m_held[i]) m_held[i] = 0;
      end else begin
         int d;
         m_changed = 0;
         if (tick && m_pend) begin
            if (m_req != m_dir && m_req != (m_dir + 2) % 4) begin
               m_dir = m_req;
               m_changed = 1;
            end
            m_pend = 0;
         end
         if (scan_valid) begin
            d = match(scan_code);
            if (m_brk) begin
               if (d >= 0) m_held[d] = 0;
               m_brk = 0; m_ext = 0;
            end else if (scan_code == 8'hF0) begin
               m_brk = 1;
            end else if (!m_ext && scan_code == 8'hE0) begin
               m_ext = 1;
            end else begin
               if (d >= 0) begin
                  m_held[d] = 1; m_req = d; m_pend = 1;
               end
               m_ext = 0;
            end
         end
      end
   end

   function automatic logic [3:0] m_keys();
      return {m_held[3], m_held[2], m_held[1], m_held[0]};
   endfunction

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (dir !== 2'(m_dir) || dir_changed !== m_changed ||
             key_held !== m_keys() || req_pending !== m_pend) begin
            failures++;
            $display("FAIL model t=%0t dut dir=%0d chg=%0b keys=%b pend=%0b exp dir=%0d chg=%0b keys=%b pend=%0b",
                     $time, dir, dir_changed, key_held, req_pending,
                     m_dir, m_changed, m_keys(), m_pend);
         end
      end
   end

   task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic lit_all(input string name, input logic [1:0] ed, input logic ec,
                          input logic [3:0] ek, input logic ep);
      lit({name, ".dir"}, 4'(dir), 4'(ed));
      lit({name, ".chg"}, 4'(dir_changed), 4'(ec));
      lit({name, ".keys"}, key_held, ek);
      lit({name, ".pend"}, 4'(req_pending), 4'(ep));
   endtask

   // Present inputs for one edge; returns just after that edge
   task automatic cyc(input logic v, input logic [7:0] b, input logic t);
      scan_valid = v; scan_code = b; tick = t;
      @(posedge clock); #1;
      scan_valid = 0; tick = 0;
   endtask

   initial begin
      #12 reset = 0;
      @(posedge clock); #1;
      lit_all("reset", 2'd1, 1'b0, 4'b0000, 1'b0);

      cyc(1, 8'h1D, 0);
      lit_all("make_up", 2'd1, 1'b0, 4'b0001, 1'b1);
      cyc(0, 8'h00, 1);
      lit_all("commit_up", 2'd0, 1'b1, 4'b0001, 1'b0);
      cyc(0, 8'h00, 0);
      lit_all("pulse_end", 2'd0, 1'b0, 4'b0001, 1'b0);

      cyc(1, 8'hF0, 0); cyc(1, 8'h1D, 0);
      lit_all("break_up", 2'd0, 1'b0, 4'b0000, 1'b0);
      cyc(1, 8'h1B, 0); cyc(0, 8'h00, 1);
      lit_all("reversal", 2'd0, 1'b0, 4'b0100, 1'b0);

      cyc(1, 8'h1D, 0);
      cyc(1, 8'hE0, 0); cyc(1, 8'hF0, 0); cyc(1, 8'h1D, 0);
      lit_all("ext_break", 2'd0, 1'b0, 4'b0100, 1'b1);
      cyc(0, 8'h00, 1);
      lit_all("same_dir", 2'd0, 1'b0, 4'b0100, 1'b0);
      cyc(1, 8'hF0, 0); cyc(1, 8'h55, 0);
      lit_all("unmapped_brk", 2'd0, 1'b0, 4'b0100, 1'b0);

      cyc(1, 8'h23, 0); cyc(1, 8'h1C, 0); cyc(0, 8'h00, 1);
      lit_all("last_wins", 2'd3, 1'b1, 4'b1110, 1'b0);

      cyc(1, 8'hE0, 0); cyc(1, 8'h1D, 0); cyc(0, 8'h00, 1);
      lit_all("ext_make", 2'd0, 1'b1, 4'b1111, 1'b0);
      cyc(1, 8'h23, 0); cyc(1, 8'h1B, 1);
      lit_all("tick_make", 2'd1, 1'b1, 4'b1111, 1'b1);
      cyc(0, 8'h00, 1);
      lit_all("second_tick", 2'd2, 1'b1, 4'b1111, 1'b0);

      up_code = 8'h23;
      cyc(1, 8'h23, 0); cyc(0, 8'h00, 1);
      lit_all("priority", 2'd2, 1'b0, 4'b1111, 1'b0);
      up_code = 8'h1D;

      cyc(1, 8'hF0, 0);
      #2 reset = 1; #2 reset = 0;
      lit_all("mid_reset", 2'd1, 1'b0, 4'b0000, 1'b0);
      @(posedge clock); #1;
      cyc(1, 8'h1D, 0);
      lit_all("fresh_byte", 2'd1, 1'b0, 4'b0001, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         logic [7:0] pool [8];
         logic [7:0] b;
         pool = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'hE0, 8'hF0, 8'hAA, 8'h12};
         if ($urandom_range(0, 199) == 0) begin
            up_code    = pool[$urandom_range(0, 3)];
            right_code = pool[$urandom_range(0, 3)];
            down_code  = pool[$urandom_range(0, 3)];
            left_code  = ($urandom_range(0, 1) == 0) ? 8'h1C : 8'h12;
         end
         if ($urandom_range(0, 4) == 0) b = 8'($urandom);
         else                           b = pool[$urandom_range(0, 7)];
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1; #2 reset = 0;
         end
         cyc(($urandom_range(0, 2) == 0), b, ($urandom_range(0, 7) == 0));
      end

      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
